// File: rtl/uart_rx_ctrl_pkg.sv
// Shared encodings and defaults for the UART receive-side controller.
package uart_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    RXC_OFF = 2'd0,
    RXC_RST = 2'd1,
    RXC_RUN = 2'd2
  } rxc_state_e;

  localparam int RXC_RST_CYC     = 2;
  localparam int RXC_FIFO_DEPTH  = 8;
  localparam int RXC_TIMEOUT_CYC = 640;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int rxc_cnt_w(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO: power-of-2 depth, wrapping pointers, separate occupancy counter.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok, wr_ok;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop_ok = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign wr_ok  = push & (~full | pop_ok);
  assign drop   = push & full & ~pop_ok;
  assign rdata  = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences uart_rx (enable, soft reset, parity config), buffers bytes and raises irq.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = RXC_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = RXC_TIMEOUT_CYC
) (
  input  logic                          sample_clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          clr_err,
  input  logic                          n_parity_cfg,
  input  logic                          ev_parity_cfg,
  output logic                          rx_en,
  output logic                          rx_rst_n,
  output logic                          n_parity,
  output logic                          ev_parity,
  input  logic                          rx_ok,
  input  logic [7:0]                    rxd_out,
  input  logic                          parity_error,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  input  logic [$clog2(FIFO_DEPTH):0]   thresh,
  output logic                          overrun,
  output logic                          perr,
  output logic                          tout,
  output logic                          irq
);

  localparam int RW = rxc_cnt_w(RXC_RST_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  rxc_state_e    state_q, state_d;
  logic [RW-1:0] rst_cnt;
  logic          rx_ok_d, perr_in_d;
  logic          push, pop_ok, drop, perr_set, lvl;
  logic [TW-1:0] tmr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RXC_OFF: if (enable) state_d = RXC_RST;
      RXC_RST: begin
        if (!enable)                           state_d = RXC_OFF;
        else if (rst_cnt == RW'(RXC_RST_CYC-1)) state_d = RXC_RUN;
      end
      RXC_RUN: begin
        if (!enable)      state_d = RXC_OFF;
        else if (clr_err) state_d = RXC_RST;
      end
      default: state_d = RXC_OFF;
    endcase
  end

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RXC_OFF;
      rst_cnt   <= '0;
      rx_en     <= 1'b0;
      rx_rst_n  <= 1'b0;
      n_parity  <= 1'b1;
      ev_parity <= 1'b0;
    end else begin
      state_q  <= state_d;
      rst_cnt  <= (state_q == RXC_RST && state_d == RXC_RST) ? rst_cnt + RW'(1) : '0;
      rx_en    <= (state_d == RXC_RUN);
      rx_rst_n <= (state_d == RXC_RUN);
      // Config only changes while uart_rx is held in reset.
      if (state_d == RXC_RST && state_q != RXC_RST) begin
        n_parity  <= n_parity_cfg;
        ev_parity <= ev_parity_cfg;
      end
    end
  end

  assign push     = rx_ok & ~rx_ok_d & (state_q == RXC_RUN);
  assign perr_set = parity_error & ~perr_in_d & (state_q == RXC_RUN);
  assign pop_ok   = rd_en & ~empty;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sample_clk),
    .rst_n (rst_n),
    .flush (state_d == RXC_OFF),
    .push  (push),
    .pop   (rd_en),
    .wdata (rxd_out),
    .rdata (rd_data),
    .empty (empty),
    .full  (full),
    .count (count),
    .drop  (drop)
  );

  assign tout = (tmr == TW'(TIMEOUT_CYC));
  assign lvl  = (thresh != '0) && (count >= thresh);

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ok_d   <= 1'b0;
      perr_in_d <= 1'b0;
      overrun   <= 1'b0;
      perr      <= 1'b0;
      tmr       <= '0;
      irq       <= 1'b0;
    end else begin
      rx_ok_d   <= rx_ok;
      perr_in_d <= parity_error;
      if (clr_err)   overrun <= 1'b0;
      else if (drop) overrun <= 1'b1;
      if (clr_err)       perr <= 1'b0;
      else if (perr_set) perr <= 1'b1;
      if (push || pop_ok || empty) tmr <= '0;
      else if (!tout)              tmr <= tmr + TW'(1);
      irq <= lvl | tout | overrun | perr;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: FIFO op table plus sequences for timing corners.
module tb_uart_rx_ctrl;

  logic       sample_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0, clr_err = 1'b0;
  logic       n_parity_cfg = 1'b0, ev_parity_cfg = 1'b0;
  logic       rx_en, rx_rst_n, n_parity, ev_parity;
  logic       rx_ok = 1'b0;
  logic [7:0] rxd_out = 8'h00;
  logic       parity_error = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full;
  logic [3:0] count;
  logic [3:0] thresh = 4'd0;
  logic       overrun, perr, tout, irq;

  int errors = 0;
  int checks = 0;

  always #5 sample_clk = ~sample_clk;

  uart_rx_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYC(640)) dut (
    .sample_clk    (sample_clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .clr_err       (clr_err),
    .n_parity_cfg  (n_parity_cfg),
    .ev_parity_cfg (ev_parity_cfg),
    .rx_en         (rx_en),
    .rx_rst_n      (rx_rst_n),
    .n_parity      (n_parity),
    .ev_parity     (ev_parity),
    .rx_ok         (rx_ok),
    .rxd_out       (rxd_out),
    .parity_error  (parity_error),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .thresh        (thresh),
    .overrun       (overrun),
    .perr          (perr),
    .tout          (tout),
    .irq           (irq)
  );

  typedef enum int {OP_PUSH, OP_POP, OP_PP, OP_CLR} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;
    int         cnt;
    logic [7:0] head;
    logic       emp;
    logic       ful;
    logic       ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(op_e op, logic [7:0] d, int c, logic [7:0] h,
                              logic e, logic f, logic o);
    vec_t v;
    v.op = op; v.data = d; v.cnt = c; v.head = h; v.emp = e; v.ful = f; v.ovr = o;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sample_clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_ok = 1'b1; rxd_out = d;
    tick();
    rx_ok = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      case (tbl[i].op)
        OP_PUSH: push_byte(tbl[i].data);
        OP_POP: begin rd_en = 1'b1; tick(); rd_en = 1'b0; end
        OP_PP: begin
          rd_en = 1'b1; rx_ok = 1'b1; rxd_out = tbl[i].data;
          tick();
          rd_en = 1'b0; rx_ok = 1'b0;
        end
        default: begin clr_err = 1'b1; tick(); clr_err = 1'b0; tick(); tick(); end
      endcase
      chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(tbl[i].head));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("v%0d full", i), 32'(full), 32'(tbl[i].ful));
      chk($sformatf("v%0d overrun", i), 32'(overrun), 32'(tbl[i].ovr));
      tick();
    end
  endtask

  initial begin
    // basic push/pop, including a pop on empty
    add(OP_PUSH, 8'h55, 1, 8'h55, 0, 0, 0);
    add(OP_PUSH, 8'hA3, 2, 8'h55, 0, 0, 0);
    add(OP_PUSH, 8'h0F, 3, 8'h55, 0, 0, 0);
    add(OP_POP,  8'h00, 2, 8'hA3, 0, 0, 0);
    add(OP_POP,  8'h00, 1, 8'h0F, 0, 0, 0);
    add(OP_POP,  8'h00, 0, 8'h00, 1, 0, 0);
    add(OP_POP,  8'h00, 0, 8'h00, 1, 0, 0);
    // starts from 22,33,44 left by the threshold sequence
    add(OP_PUSH, 8'h55, 4, 8'h22, 0, 0, 0);
    add(OP_PUSH, 8'h66, 5, 8'h22, 0, 0, 0);
    add(OP_PUSH, 8'h77, 6, 8'h22, 0, 0, 0);
    add(OP_PUSH, 8'h88, 7, 8'h22, 0, 0, 0);
    add(OP_PUSH, 8'h99, 8, 8'h22, 0, 1, 0);
    add(OP_PUSH, 8'hEE, 8, 8'h22, 0, 1, 1);
    add(OP_CLR,  8'h00, 8, 8'h22, 0, 1, 0);
    add(OP_PP,   8'hAA, 8, 8'h33, 0, 1, 0);
    add(OP_POP,  8'h00, 7, 8'h44, 0, 0, 0);
    add(OP_POP,  8'h00, 6, 8'h55, 0, 0, 0);
    add(OP_POP,  8'h00, 5, 8'h66, 0, 0, 0);
    add(OP_POP,  8'h00, 4, 8'h77, 0, 0, 0);
    add(OP_POP,  8'h00, 3, 8'h88, 0, 0, 0);
    add(OP_POP,  8'h00, 2, 8'h99, 0, 0, 0);
    add(OP_POP,  8'h00, 1, 8'hAA, 0, 0, 0);
    add(OP_POP,  8'h00, 0, 8'h00, 1, 0, 0);

    // reset state
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst rx_en", 32'(rx_en), 0);
    chk("rst rx_rst_n", 32'(rx_rst_n), 0);
    chk("rst n_parity", 32'(n_parity), 1);
    chk("rst ev_parity", 32'(ev_parity), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst count", 32'(count), 0);
    chk("rst rd_data", 32'(rd_data), 0);
    chk("rst flags", 32'({overrun, perr, tout, irq}), 0);

    // enable: two cycles of soft reset, config latched on entry
    enable = 1'b1; n_parity_cfg = 1'b0; ev_parity_cfg = 1'b1;
    tick();
    chk("en c1 rx_rst_n", 32'(rx_rst_n), 0);
    chk("en c1 rx_en", 32'(rx_en), 0);
    chk("en n_parity", 32'(n_parity), 0);
    chk("en ev_parity", 32'(ev_parity), 1);
    tick();
    chk("en c2 rx_rst_n", 32'(rx_rst_n), 0);
    tick();
    chk("en c3 rx_rst_n", 32'(rx_rst_n), 1);
    chk("en c3 rx_en", 32'(rx_en), 1);
    n_parity_cfg = 1'b1; ev_parity_cfg = 1'b0;
    tick();
    chk("run cfg hold n", 32'(n_parity), 0);
    chk("run cfg hold ev", 32'(ev_parity), 1);
    n_parity_cfg = 1'b0; ev_parity_cfg = 1'b1;

    run_vecs(0, 6);

    // level interrupt
    thresh = 4'd4;
    push_byte(8'h11); tick();
    push_byte(8'h22); tick();
    push_byte(8'h33); tick();
    push_byte(8'h44);
    chk("lvl count4", 32'(count), 4);
    chk("lvl irq N+1", 32'(irq), 0);
    tick();
    chk("lvl irq N+2", 32'(irq), 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("lvl pop count", 32'(count), 3);
    chk("lvl pop irq N+1", 32'(irq), 1);
    tick();
    chk("lvl pop irq N+2", 32'(irq), 0);
    thresh = 4'd0;

    run_vecs(7, 22);

    // parity error: flag, no push, then clr_err soft reset keeps FIFO
    parity_error = 1'b1;
    tick();
    chk("perr set", 32'(perr), 1);
    chk("perr no push", 32'(count), 0);
    tick();
    chk("perr irq", 32'(irq), 1);
    push_byte(8'h5A); tick();
    n_parity_cfg = 1'b1; ev_parity_cfg = 1'b0;
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    parity_error = 1'b0;
    chk("clr perr", 32'(perr), 0);
    chk("clr c1 rx_rst_n", 32'(rx_rst_n), 0);
    chk("clr n_parity", 32'(n_parity), 1);
    chk("clr ev_parity", 32'(ev_parity), 0);
    tick();
    chk("clr c2 rx_rst_n", 32'(rx_rst_n), 0);
    tick();
    chk("clr c3 rx_rst_n", 32'(rx_rst_n), 1);
    chk("clr c3 rx_en", 32'(rx_en), 1);
    chk("clr fifo count", 32'(count), 1);
    chk("clr fifo head", 32'(rd_data), 32'h5A);

    // character timeout
    push_byte(8'h6B);
    repeat (639) tick();
    chk("tout 639", 32'(tout), 0);
    chk("tout irq 639", 32'(irq), 0);
    tick();
    chk("tout 640", 32'(tout), 1);
    tick();
    chk("tout irq", 32'(irq), 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("tout pop clear", 32'(tout), 0);
    chk("tout pop head", 32'(rd_data), 32'h6B);
    tick();
    chk("tout pop irq", 32'(irq), 0);

    // disable drops to OFF and empties the FIFO
    enable = 1'b0;
    tick();
    chk("off rx_en", 32'(rx_en), 0);
    chk("off rx_rst_n", 32'(rx_rst_n), 0);
    chk("off empty", 32'(empty), 1);
    chk("off count", 32'(count), 0);
    chk("off rd_data", 32'(rd_data), 0);
    push_byte(8'h77); tick();
    chk("off rx_ok ignored", 32'(count), 0);

    // rx_ok held high across RST->RUN must not push
    rx_ok = 1'b1; rxd_out = 8'h12; enable = 1'b1;
    repeat (5) tick();
    chk("no false edge rx_en", 32'(rx_en), 1);
    chk("no false edge", 32'(count), 0);
    rx_ok = 1'b0;
    tick();

    // async reset mid-operation
    push_byte(8'hC3); tick();
    chk("pre-arst count", 32'(count), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst count", 32'(count), 0);
    chk("arst empty", 32'(empty), 1);
    chk("arst rd_data", 32'(rd_data), 0);
    chk("arst rx_en", 32'(rx_en), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
